// File: rtl/uart_gpio_top.sv
// UART command bridge: 8N1 RX/TX, tri-state GPIO port and LED.
// Command bytes W/E/L take one argument; R and ? queue a reply.
module uart_gpio_top #(
  parameter int PARAM1       = 0,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rxd,
  output logic uart_txd,
  inout  wire  [7:0] gpio,
  output logic led
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] START_BYTE = 8'(PARAM1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic {P_IDLE, P_ARG} p_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  p_state_t  p_state, p_next;

  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic [7:0]    rx_data;

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_busy, tx_accept;

  logic [7:0] gpio_out, gpio_oe;
  logic [7:0] gpio_s1, gpio_sync;
  logic [7:0] arg_cmd;
  logic [7:0] pend_data, resp_data;
  logic       pend_v, resp_load, started;

  for (genvar i = 0; i < 8; i++) begin : g_pin
    assign gpio[i] = gpio_oe[i] ? gpio_out[i] : 1'bz;
  end

  assign rx_data   = rx_shift;
  assign tx_busy   = (tx_state == TX_BUSY);
  assign tx_accept = !tx_busy && pend_v;

  always_comb begin
    rx_next  = rx_state;
    rx_valid = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_END)
                  rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_END && rx_bit == 3'd7)
                  rx_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_END) begin
                  rx_next  = rx_s2 ? RX_IDLE : RX_WAIT;
                  rx_valid = rx_s2;
                end
      RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_state != rx_next ||
          (rx_state == RX_DATA && rx_cnt == BIT_END))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_DATA && rx_cnt == BIT_END) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE: if (pend_v) tx_next = TX_BUSY;
      TX_BUSY: if (tx_cnt == BIT_END && tx_bit == 4'd9)
                 tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Bit 0 is the start bit; the stop bit is the 1 shifted in at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_accept) begin
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_shift <= {1'b1, pend_data};
        uart_txd <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_bit   <= tx_bit + 1'b1;
          uart_txd <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    p_next    = p_state;
    resp_load = 1'b0;
    resp_data = '0;
    unique case (p_state)
      P_IDLE: if (rx_valid) begin
        unique case (1'b1)
          rx_data == 8'h57,
          rx_data == 8'h45,
          rx_data == 8'h4C: p_next = P_ARG;
          rx_data == 8'h52: begin
            resp_load = 1'b1;
            resp_data = gpio_sync;
          end
          rx_data == 8'h3F: begin
            resp_load = 1'b1;
            resp_data = 8'hA5;
          end
          default: ;
        endcase
      end
      P_ARG:   if (rx_valid) p_next = P_IDLE;
      default: p_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state   <= P_IDLE;
      arg_cmd   <= '0;
      gpio_out  <= '0;
      gpio_oe   <= '0;
      led       <= 1'b0;
      gpio_s1   <= '0;
      gpio_sync <= '0;
      pend_data <= '0;
      pend_v    <= 1'b0;
      started   <= 1'b0;
    end else begin
      p_state   <= p_next;
      gpio_s1   <= gpio;
      gpio_sync <= gpio_s1;
      started   <= 1'b1;
      if (p_state == P_IDLE && rx_valid)
        arg_cmd <= rx_data;
      if (p_state == P_ARG && rx_valid) begin
        unique case (1'b1)
          arg_cmd == 8'h57: gpio_out <= rx_data;
          arg_cmd == 8'h45: gpio_oe  <= rx_data;
          arg_cmd == 8'h4C: led      <= rx_data[0];
          default: ;
        endcase
      end
      // Last response wins; the startup byte only loads once.
      if (!started && PARAM1 != 0) begin
        pend_data <= START_BYTE;
        pend_v    <= 1'b1;
      end else if (resp_load) begin
        pend_data <= resp_data;
        pend_v    <= 1'b1;
      end else if (tx_accept) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_gpio_top.sv
// Directed bench for uart_gpio_top with TX looped back into RX.
// The bench UART drive is ANDed with uart_txd on the RX line.
module tb_uart_gpio_top;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic tb_rx;
  logic uart_rxd;
  logic uart_txd;
  logic led;
  logic tb_drv;
  logic [7:0] tb_val;
  wire  [7:0] gpio;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign uart_rxd = tb_rx & uart_txd;
  assign gpio = tb_drv ? tb_val : 8'hzz;

  uart_gpio_top #(.PARAM1(0), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .gpio(gpio),
    .led(led)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    tb_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      tick(CPB);
    end
    tb_rx = stop;
    tick(CPB);
    tb_rx = 1'b1;
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (uart_txd === 1'b0) lows++;
    end
  endtask

  // Sample offsets are relative to the first negedge that sees the start bit.
  task automatic get_frame(output logic [7:0] d,
                           output logic stop,
                           output logic start_end);
    int n;
    d = '0;
    stop = 1'b0;
    start_end = 1'b1;
    n = 0;
    while (uart_txd !== 1'b0 && n < 600) begin
      tick(1);
      n++;
    end
    if (uart_txd !== 1'b0) begin
      chk("tx_start", uart_txd, 1'b0);
      return;
    end
    tick(15);
    start_end = uart_txd;
    tick(9);
    for (int i = 0; i < 8; i++) begin
      d[i] = uart_txd;
      tick(CPB);
    end
    stop = uart_txd;
  endtask

  logic [7:0] d;
  logic       s, se;
  int         lows;

  initial begin
    rst = 1'b1;
    tb_rx = 1'b1;
    tb_drv = 1'b0;
    tb_val = 8'h00;
    #101;
    rst = 1'b0;
    tick(1);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_oe", dut.gpio_oe, 8'h00);
    chk("rst_out", dut.gpio_out, 8'h00);
    chk("rst_led", led, 1'b0);
    count_low(2000, lows);
    chk("rst_quiet", lows, 0);

    send_byte(8'h45, 1'b1); tick(20);
    send_byte(8'hFF, 1'b1); tick(20);
    send_byte(8'h57, 1'b1); tick(20);
    send_byte(8'h3C, 1'b1); tick(20);
    chk("pins_3c", gpio, 8'h3C);

    send_byte(8'h45, 1'b1); tick(20);
    send_byte(8'h0F, 1'b1); tick(20);
    chk("oe_0f", dut.gpio_oe, 8'h0F);
    chk("pins_lo", gpio[3:0], 4'hC);

    send_byte(8'h4C, 1'b1); tick(20);
    send_byte(8'h01, 1'b1); tick(4);
    chk("led_on", led, 1'b1);
    send_byte(8'h4C, 1'b1); tick(20);
    send_byte(8'h02, 1'b1); tick(4);
    chk("led_off", led, 1'b0);

    send_byte(8'h57, 1'b0);
    tick(40);
    send_byte(8'h00, 1'b1); tick(20);
    chk("framing", gpio[3:0], 4'hC);

    send_byte(8'h4C, 1'b1); tick(20);
    tb_rx = 1'b0;
    tick(4);
    tb_rx = 1'b1;
    tick(200);
    send_byte(8'h00, 1'b1); tick(20);
    chk("glitch", led, 1'b0);
    send_byte(8'h4C, 1'b1); tick(20);
    send_byte(8'h03, 1'b1); tick(20);
    chk("led_l03", led, 1'b1);

    fork
      send_byte(8'h3F, 1'b1);
      get_frame(d, s, se);
    join
    chk("tx_a5", d, 8'hA5);
    chk("tx_a5_stop", s, 1'b1);
    chk("tx_a5_start", se, 1'b0);
    count_low(400, lows);
    chk("a5_echo_quiet", lows, 0);

    send_byte(8'h45, 1'b1); tick(20);
    send_byte(8'h00, 1'b1); tick(4);
    tb_val = 8'h52;
    tb_drv = 1'b1;
    tick(5);
    fork
      send_byte(8'h52, 1'b1);
      get_frame(d, s, se);
    join
    chk("tx_r1", d, 8'h52);
    chk("tx_r1_stop", s, 1'b1);
    get_frame(d, s, se);
    chk("tx_r2", d, 8'h52);
    tick(30);
    chk("stream_low", uart_txd, 1'b0);

    rst = 1'b1;
    #1;
    chk("rst_mid_txd", uart_txd, 1'b1);
    chk("rst_mid_led", led, 1'b0);
    tick(3);
    rst = 1'b0;
    count_low(400, lows);
    chk("post_rst_quiet", lows, 0);
    chk("post_rst_pins", gpio, 8'h52);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
